// File: rtl/sevenseg_display_port.sv
// CPU-mapped 4-digit multiplexed seven-segment port. Writes go to a pending register and reach the
// displayed shadow copy only at frame wrap. Outputs are registered one cycle after idx/shadow/mask.
module sevenseg_display_port #(
    parameter int SCAN_DIV_BITS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        a0,
    output logic [15:0] data_out,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [SCAN_DIV_BITS-1:0] PRESC_ONE = {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};

    logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
    logic [1:0]               idx_q, idx_d;
    logic [15:0]              pending_q, pending_d;
    logic [15:0]              shadow_q, shadow_d;
    logic [3:0]               en_mask_q, en_mask_d;
    logic [3:0]               dp_mask_q, dp_mask_d;
    logic                     frame_q, frame_d;
    logic [3:0]               anode_q, anode_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;

    logic                     tick;
    logic                     wrap;
    logic [3:0]               digit;
    logic                     digit_on;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = &presc_q;
        wrap      = tick && (idx_q == 2'd3);
        presc_d   = presc_q + PRESC_ONE;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        shadow_d  = wrap ? pending_q : shadow_q;
        pending_d = pending_q;
        en_mask_d = en_mask_q;
        dp_mask_d = dp_mask_q;
        frame_d   = frame_q;

        if (wr) begin
            if (!a0) begin
                pending_d = data_in;
            end else if (data_in[15]) begin
                pending_d = {pending_q[11:0], data_in[3:0]};
            end else if (data_in[14]) begin
                frame_d = 1'b0;
            end else begin
                en_mask_d = data_in[3:0];
                dp_mask_d = data_in[7:4];
            end
        end
        // A wrap in the same cycle as a frame-clear keeps the flag set.
        if (wrap) begin
            frame_d = 1'b1;
        end
    end

    always_comb begin
        digit    = shadow_q[{idx_q, 2'b00} +: 4];
        digit_on = en_mask_q[idx_q];
        anode_d  = digit_on ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d    = digit_on ? hex7(digit) : 7'b1111111;
        dp_d     = ~(dp_mask_q[idx_q] & digit_on);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= 2'd0;
            pending_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            en_mask_q <= 4'hF;
            dp_mask_q <= 4'h0;
            frame_q   <= 1'b0;
            anode_q   <= 4'b1111;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            en_mask_q <= en_mask_d;
            dp_mask_q <= dp_mask_d;
            frame_q   <= frame_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign data_out = a0 ? {7'b0000000, frame_q, dp_mask_q, en_mask_q} : pending_q;
    assign anode    = anode_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_sevenseg_display_port.sv
// Directed bench for sevenseg_display_port with a 4-clk scan tick; cyc counts posedges since reset release.
module tb_sevenseg_display_port;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        wr;
    logic        a0;
    logic [15:0] data_out;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0]  an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [15:0] rb;

    sevenseg_display_port #(.SCAN_DIV_BITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .wr       (wr),
        .a0       (a0),
        .data_out (data_out),
        .anode    (anode),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick_clk();
    endtask

    task automatic wr_reg(input logic sel, input logic [15:0] d);
        a0      = sel;
        data_in = d;
        wr      = 1'b1;
        tick_clk();
        wr      = 1'b0;
    endtask

    task automatic rd(input logic sel, output logic [15:0] v);
        a0 = sel;
        #1;
        v = data_out;
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; a0 = 1'b0; data_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_anode", {12'h0, anode}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        rd(1'b0, rb); chk("rst_pending", rb, 16'h0000);
        rd(1'b1, rb); chk("rst_status", rb, 16'h000F);
        rst = 1'b0;
        cyc = 0;

        // Idle scan: each digit held 4 clk, all showing 0.
        for (int k = 1; k <= 32; k++) begin
            tick_clk();
            chk("t1_anode", {12'h0, anode}, {12'h0, an_tbl[((cyc - 1) / 4) % 4]});
            chk("t1_seg", {9'h0, seg}, 16'h0001);
            chk("t1_dp", {15'h0, dp}, 16'h0001);
        end

        // Mid-frame value write; display updates only after wrap at cyc 48.
        wait_cyc(36);
        wr_reg(1'b0, 16'h12AF);
        rd(1'b0, rb); chk("t2_readback", rb, 16'h12AF);
        wait_cyc(40);
        chk("t2_nowrap_seg", {9'h0, seg}, 16'h0001);
        chk("t2_nowrap_anode", {12'h0, anode}, 16'h000D);
        wait_cyc(49);
        chk("t2_d0_anode", {12'h0, anode}, 16'h000E);
        chk("t2_d0_seg", {9'h0, seg}, 16'h0038);
        wait_cyc(53);
        chk("t2_d1_anode", {12'h0, anode}, 16'h000D);
        chk("t2_d1_seg", {9'h0, seg}, 16'h0008);
        wait_cyc(57);
        chk("t2_d2_seg", {9'h0, seg}, 16'h0012);
        wait_cyc(61);
        chk("t2_d3_anode", {12'h0, anode}, 16'h0007);
        chk("t2_d3_seg", {9'h0, seg}, 16'h004F);

        // Digit shift-in.
        wait_cyc(65);
        wr_reg(1'b0, 16'h1234);
        wr_reg(1'b1, 16'h8005);
        rd(1'b0, rb); chk("t3_shift1", rb, 16'h2345);
        wr_reg(1'b1, 16'h8005);
        rd(1'b0, rb); chk("t3_shift2", rb, 16'h3455);
        wr_reg(1'b1, 16'h8005);
        rd(1'b0, rb); chk("t3_shift3", rb, 16'h4555);

        // Masks: digits 0 and 2 enabled, dp on digits 0 and 1 (visible only on 0).
        wr_reg(1'b1, 16'h4000);
        wr_reg(1'b1, 16'h0035);
        rd(1'b1, rb); chk("t4_status", rb, 16'h0035);
        wait_cyc(81);
        chk("t4_s0_anode", {12'h0, anode}, 16'h000E);
        chk("t4_s0_seg", {9'h0, seg}, 16'h0024);
        chk("t4_s0_dp", {15'h0, dp}, 16'h0000);
        wait_cyc(85);
        chk("t4_s1_anode", {12'h0, anode}, 16'h000F);
        chk("t4_s1_seg", {9'h0, seg}, 16'h007F);
        chk("t4_s1_dp", {15'h0, dp}, 16'h0001);
        wait_cyc(89);
        chk("t4_s2_anode", {12'h0, anode}, 16'h000B);
        chk("t4_s2_seg", {9'h0, seg}, 16'h0024);
        chk("t4_s2_dp", {15'h0, dp}, 16'h0001);
        wait_cyc(93);
        chk("t4_s3_anode", {12'h0, anode}, 16'h000F);
        chk("t4_s3_seg", {9'h0, seg}, 16'h007F);
        chk("t4_s3_dp", {15'h0, dp}, 16'h0001);

        // Frame flag: set by wrap at 96, cleared off-wrap, set wins on wrap at 112.
        wait_cyc(97);
        rd(1'b1, rb); chk("t5_frame_set", rb, 16'h0135);
        wr_reg(1'b1, 16'h4000);
        rd(1'b1, rb); chk("t5_frame_clr", rb, 16'h0035);
        wait_cyc(111);
        rd(1'b1, rb); chk("t5_pre_wrap", rb, 16'h0035);
        wr_reg(1'b1, 16'h4000);
        rd(1'b1, rb); chk("t5_clr_on_wrap", rb, 16'h0135);

        // Reset mid-frame while idx = 2 with BEEF displayed.
        wr_reg(1'b0, 16'hBEEF);
        wait_cyc(138);
        chk("t6_pre_anode", {12'h0, anode}, 16'h000B);
        chk("t6_pre_seg", {9'h0, seg}, 16'h0030);
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        cyc = 0;
        chk("t6_rst_anode", {12'h0, anode}, 16'h000F);
        chk("t6_rst_seg", {9'h0, seg}, 16'h007F);
        chk("t6_rst_dp", {15'h0, dp}, 16'h0001);
        rd(1'b0, rb); chk("t6_rst_pending", rb, 16'h0000);
        rd(1'b1, rb); chk("t6_rst_status", rb, 16'h000F);
        tick_clk();
        chk("t6_after_anode", {12'h0, anode}, 16'h000E);
        chk("t6_after_seg", {9'h0, seg}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
